seven_segment_scanner: RTL and testbench

SEVEN_SEGMENT_SCANNER -- requirements
Module: seven_segment_scanner

---
 rtl/seven_segment_scanner.sv | 121 ++++++++++++
 tb/tb_seven_segment_scanner.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/seven_segment_scanner.sv
// Multiplexed hex seven-segment scanner with ghost-blank phases.
// Optional: SSD_LEADING_ZERO_BLANK_EN blanks leading zero digits.
module seven_segment_scanner #(
  parameter int NUM_DIGITS = 8,
  parameter int DIV_COUNT  = 65536
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  output logic [6:0]              seg,
  output logic                    dp_n,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_start
);

  localparam int PH = 2 * NUM_DIGITS;
  localparam int PW = $clog2(PH);
  localparam int DW = $clog2(DIV_COUNT);

  logic [DW-1:0]           div_q;
  logic [PW-1:0]           phase_q;
  logic [PW-1:0]           phase_nx;
  logic [4*NUM_DIGITS-1:0] val_q;
  logic [NUM_DIGITS-1:0]   dp_q;
  logic [NUM_DIGITS-1:0]   en_q;
  logic [4*NUM_DIGITS-1:0] val_src;
  logic [NUM_DIGITS-1:0]   dp_src;
  logic [NUM_DIGITS-1:0]   en_src;
  logic [NUM_DIGITS-1:0]   lz_ok;
  logic [NUM_DIGITS-1:0]   an_nx;
  logic [6:0]              seg_nx;
  logic                    dp_nx;
  logic                    tick;
  logic                    wrap;

  function automatic logic [6:0] font(input logic [3:0] d);
    unique case (d)
      4'h0: font = 7'b0000001;
      4'h1: font = 7'b1001111;
      4'h2: font = 7'b0010010;
      4'h3: font = 7'b0000110;
      4'h4: font = 7'b1001100;
      4'h5: font = 7'b0100100;
      4'h6: font = 7'b0100000;
      4'h7: font = 7'b0001111;
      4'h8: font = 7'b0000000;
      4'h9: font = 7'b0000100;
      4'hA: font = 7'b0001000;
      4'hB: font = 7'b1100000;
      4'hC: font = 7'b0110001;
      4'hD: font = 7'b1000010;
      4'hE: font = 7'b0110000;
      default: font = 7'b0111000;
    endcase
  endfunction

  assign tick     = div_q == DW'(DIV_COUNT - 1);
  assign wrap     = phase_q == PW'(PH - 1);
  assign phase_nx = wrap ? '0 : phase_q + PW'(1);

  // Entering phase 0 shows the fresh snapshot being captured this edge
  assign val_src = wrap ? value    : val_q;
  assign dp_src  = wrap ? dp       : dp_q;
  assign en_src  = wrap ? digit_en : en_q;

`ifdef SSD_LEADING_ZERO_BLANK_EN
  always_comb begin
    lz_ok = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      lz_ok[i] = (i == 0) || dp_src[i] ||
                 ((val_src >> (4 * i)) != '0);
    end
  end
`else
  assign lz_ok = '1;
`endif

  always_comb begin
    an_nx  = '1;
    seg_nx = 7'b1111111;
    dp_nx  = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (phase_nx == PW'(2 * i) && en_src[i] && lz_ok[i]) begin
        an_nx[i] = 1'b0;
        seg_nx   = font(val_src[4*i +: 4]);
        dp_nx    = ~dp_src[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_q       <= '0;
      phase_q     <= PW'(PH - 1);
      val_q       <= '0;
      dp_q        <= '0;
      en_q        <= '0;
      an          <= '1;
      seg         <= 7'b1111111;
      dp_n        <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      div_q       <= tick ? '0 : div_q + DW'(1);
      frame_start <= tick && wrap;
      if (tick) begin
        phase_q <= phase_nx;
        an      <= an_nx;
        seg     <= seg_nx;
        dp_n    <= dp_nx;
        if (wrap) begin
          val_q <= value;
          dp_q  <= dp;
          en_q  <= digit_en;
        end
      end
    end
  end

endmodule

// File: tb/tb_seven_segment_scanner.sv
// Randomized bench for seven_segment_scanner against a time-based model.
// Model honours SSD_LEADING_ZERO_BLANK_EN when defined.
module tb_seven_segment_scanner;

  localparam int N   = 4;
  localparam int DIV = 4;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [4*N-1:0] value = '0;
  logic [N-1:0]   dp = '0;
  logic [N-1:0]   digit_en = '0;
  logic [6:0]     seg;
  logic           dp_n;
  logic [N-1:0]   an;
  logic           frame_start;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  seven_segment_scanner #(.NUM_DIGITS(N), .DIV_COUNT(DIV)) dut (
    .clk(clk), .rst_n(rst_n), .value(value), .dp(dp),
    .digit_en(digit_en), .seg(seg), .dp_n(dp_n), .an(an),
    .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] ref_font(input int d);
    logic [6:0] t [16] = '{
      7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
      7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
      7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
      7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};
    return t[d];
  endfunction

  int             cyc;
  logic [4*N-1:0] s_val;
  logic [N-1:0]   s_dp, s_en;
  logic [N-1:0]   e_an;
  logic [6:0]     e_seg;
  logic           e_dpn, e_fs;

  function automatic bit shown(int k);
    int msd;
    if (!s_en[k]) return 0;
`ifdef SSD_LEADING_ZERO_BLANK_EN
    msd = 0;
    for (int i = 0; i < N; i++)
      if (((s_val >> (4 * i)) & 'hF) != 0) msd = i;
    return (k <= msd) || s_dp[k];
`else
    msd = k;
    return msd == k;
`endif
  endfunction

  // Phase entered at tick m (m-th multiple of DIV since release) is (m-1) mod 2N
  always @(posedge clk) begin
    int p, k;
    if (!rst_n) begin
      cyc = 0; s_val = '0; s_dp = '0; s_en = '0;
      e_an = '1; e_seg = 7'b1111111; e_dpn = 1'b1; e_fs = 1'b0;
    end else begin
      cyc++;
      e_fs = 1'b0;
      if (cyc % DIV == 0) begin
        p = (cyc / DIV - 1) % (2 * N);
        if (p == 0) begin
          s_val = value; s_dp = dp; s_en = digit_en; e_fs = 1'b1;
        end
        e_an = '1; e_seg = 7'b1111111; e_dpn = 1'b1;
        if (p % 2 == 0) begin
          k = p / 2;
          if (shown(k)) begin
            e_an[k] = 1'b0;
            e_seg   = ref_font(int'((s_val >> (4 * k)) & 'hF));
            e_dpn   = ~s_dp[k];
          end
        end
      end
    end
  end

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("an", 32'(an), 32'(e_an));
      check("seg", 32'(seg), 32'(e_seg));
      check("dp_n", 32'(dp_n), 32'(e_dpn));
      check("frame_start", 32'(frame_start), 32'(e_fs));
      check("one_hot", 32'($countones(~an) <= 1), 32'd1);
    end
  end

  logic [N-1:0] lit_an [9] = '{4'b1110, 4'b1111, 4'b1101, 4'b1111,
    4'b1011, 4'b1111, 4'b0111, 4'b1111, 4'b1110};
  logic [6:0] lit_seg [9] = '{7'b1001100, 7'b1111111, 7'b0000110,
    7'b1111111, 7'b0010010, 7'b1111111, 7'b1001111, 7'b1111111,
    7'b1001100};

  initial begin
    value = 16'h1234; digit_en = 4'hF; dp = 4'h0;
    repeat (3) @(posedge clk);
    #1;
    chk_en = 1'b1;
    check("rst_an", 32'(an), 32'hF);
    check("rst_seg", 32'(seg), 32'h7F);
    check("rst_fs", 32'(frame_start), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    for (int t = 0; t < 9; t++) begin
      repeat (DIV) @(posedge clk);
      #1;
      check("lit_an", 32'(an), 32'(lit_an[t]));
      check("lit_seg", 32'(seg), 32'(lit_seg[t]));
      check("lit_fs", 32'(frame_start), 32'(t % 8 == 0));
    end
    @(negedge clk);
    value = 16'hABCD;
    digit_en = 4'b0101; dp = 4'b0100;
    repeat (80) @(negedge clk);
    digit_en = 4'h0;
    repeat (40) @(negedge clk);
    value = 16'h0050; digit_en = 4'hF; dp = 4'h0;
    repeat (40) @(negedge clk);
    value = 16'h0000;
    repeat (40) @(negedge clk);
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      rst_n = ($urandom_range(0, 299) != 0);
      if ($urandom_range(0, 15) == 0) begin
        value = 16'($urandom);
        if ($urandom_range(0, 2) == 0) value = value & 16'h00FF;
        if ($urandom_range(0, 4) == 0) value = value & 16'h000F;
      end
      if ($urandom_range(0, 25) == 0) dp = 4'($urandom);
      if ($urandom_range(0, 25) == 0)
        digit_en = ($urandom_range(0, 2) == 0) ? 4'hF : 4'($urandom);
    end
    @(negedge clk);
    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
